serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Bit-serial, LSB-first subtractor that computes diff = a - b over WIDTH clock cycles.
- Uses one full-subtractor cell and a borrow flop.
- Complements the combinational adder cells in the Adders library. Used where area matters more than latency.
- Operands are captured on a start handshake. Result, borrow and signed overflow are presented with a one-cycle done pulse.

Parameters:
- WIDTH, 8, operand and result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  minuend; captured on accepted start
- b  input  WIDTH  subtrahend; captured on accepted start
- busy  output  1  high while an operation is in progress (SHIFT state)
- done  output  1  one-cycle pulse; result outputs valid
- diff  output  WIDTH  a - b modulo 2^WIDTH
- borrow_out  output  1  final borrow; 1 iff a < b unsigned
- overflow  output  1  signed (two's complement) overflow of a - b

Behaviour:
- Reset:
  - Synchronous and active-low. rst_n is sampled only on the rising edge of clk.
  - On reset: state=IDLE, busy=0, done=0, diff=0, borrow_out=0, overflow=0.
  - Internal shift registers, bit counter and borrow flop are all cleared.
- States:
  - IDLE: waiting for start.
  - SHIFT: processing one bit per cycle.
  - DONE: results just completed.
- IDLE:
  - On the edge where start=1, capture a and b into shift registers, clear the borrow flop and counter=0.
  - Go to SHIFT and set busy=1 from that edge.
  - If start=0, remain in IDLE.
- SHIFT, each edge:
  - Take the LSBs ai and bi of the shift registers.
  - Compute d = ai ^ bi ^ bin.
  - Compute bout = (~ai & bi) | (~(ai ^ bi) & bin).
  - Shift d into the MSB of the result register, shift both operand registers right by 1, set bin <= bout, counter++.
- End of SHIFT:
  - On the edge processing bit WIDTH-1, go to DONE.
  - On that edge: diff <= the completed result, borrow_out <= bout, overflow <= (a[MSB] != b[MSB]) && (d_msb != a[MSB]), busy <= 0, done <= 1.
- DONE: lasts exactly one cycle with done=1, then returns to IDLE with done=0.
- Latency: start accepted at edge 0 → done high in the cycle after edge WIDTH (WIDTH=8: done high between edges 8 and 9).
- Throughput: a new start is accepted no earlier than edge WIDTH+1, i.e. once back in IDLE.
- start during SHIFT or DONE is ignored; there is no queuing, and a and b may change freely.
- diff, borrow_out and overflow hold their values from DONE until the next operation completes. They are not cleared on a new start.
- Reset mid-operation: abort immediately to reset values. No done pulse is produced for the aborted operation.
- a == b: diff=0, borrow_out=0, overflow=0.
- Wrap-around: the result is modulo 2^WIDTH. borrow_out reports the unsigned underflow.

Test Plan:
- WIDTH=8, a=0x05, b=0x03, start pulse → done exactly 8 cycles after the start edge (edge 8), diff=0x02, borrow_out=0, overflow=0. busy high for 8 cycles.
- a=0x03, b=0x05 → diff=0xFE, borrow_out=1, overflow=0.
- a=0x80, b=0x01 → diff=0x7F, borrow_out=0, overflow=1.
- a=0x7F, b=0xFF → diff=0x80, borrow_out=1, overflow=1.
- Start a=0x10, b=0x01, then start=1 with a=0xFF, b=0x00 held during busy → single done with diff=0x0F. The second start is accepted only once back in IDLE.
- rst_n=0 at cycle 4 of an operation → all outputs 0 next edge, no done. Then exhaustive WIDTH=4 sweep (256 pairs) versus a reference model: diff, borrow_out and overflow all match.

Source files
------------

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial, LSB-first subtractor. One full-subtractor cell and a borrow
//   flop compute diff = a - b over WIDTH clock cycles.
//
//   Ports:
//     clk        - rising-edge clock
//     rst_n      - synchronous active-low reset
//     start      - request, sampled only while idle
//     a, b       - minuend / subtrahend, captured on an accepted start
//     busy       - high while bits are being processed
//     done       - one-cycle pulse, result outputs valid
//     diff       - a - b modulo 2^WIDTH (held until the next completion)
//     borrow_out - final borrow, 1 iff a < b unsigned
//     overflow   - two's complement overflow of a - b
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             overflow
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    // Holds the WIDTH-1 low result bits; the last bit is merged in directly
    // on the final edge, so no spare stage is needed.
    logic [WIDTH-2:0] res_q, res_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             bin_q, bin_d;
    // Operand sign bits, kept because the shift registers lose them.
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             ovf_q, ovf_d;

    logic             ai, bi, d, bout;
    logic [WIDTH-1:0] res_full;

    // Full-subtractor cell
    assign ai       = a_sh_q[0];
    assign bi       = b_sh_q[0];
    assign d        = ai ^ bi ^ bin_q;
    assign bout     = (~ai & bi) | (~(ai ^ bi) & bin_q);
    assign res_full = {d, res_q};

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        ovf_d    = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                res_d  = res_full[WIDTH-1:1];
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                bin_d  = bout;
                cnt_d  = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_full;
                    borrow_d = bout;
                    // Overflow only when signs differ and the result sign
                    // disagrees with the minuend.
                    ovf_d    = (a_msb_q != b_msb_q) && (d != a_msb_q);
                    cnt_d    = '0;
                    state_d  = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy       = (state_q == SHIFT);
    assign done       = (state_q == DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: a WIDTH=8 instance tracked cycle by cycle
// against an arithmetic reference, and a WIDTH=4 instance swept over all
// operand pairs.
module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    // WIDTH=8 instance
    logic       start8 = 1'b0;
    logic [7:0] a8 = '0, b8 = '0;
    logic       busy8, done8, bor8, ovf8;
    logic [7:0] diff8;

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .diff(diff8),
        .borrow_out(bor8), .overflow(ovf8)
    );

    // WIDTH=4 instance
    logic       start4 = 1'b0;
    logic [3:0] a4 = '0, b4 = '0;
    logic       busy4, done4, bor4, ovf4;
    logic [3:0] diff4;

    serial_subtractor #(.WIDTH(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .diff(diff4),
        .borrow_out(bor4), .overflow(ovf4)
    );

    // Reference: {overflow, borrow, diff} of x - y at width w, from plain
    // integer arithmetic.
    function automatic logic [33:0] ref_sub(input int w, input logic [31:0] x,
                                            input logic [31:0] y);
        longint sx, sy, r, lim;
        logic [31:0] mask;
        logic [33:0] o;
        mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
        sx   = x[w-1] ? longint'(x) - (longint'(1) << w) : longint'(x);
        sy   = y[w-1] ? longint'(y) - (longint'(1) << w) : longint'(y);
        r    = sx - sy;
        lim  = longint'(1) << (w - 1);
        o[31:0] = (x - y) & mask;
        o[32]   = (x < y);
        o[33]   = (r >= lim) || (r < -lim);
        return o;
    endfunction

    // Timing model of the 8-bit unit: m_cnt=0 idle, 1..8 busy, 9 done.
    int         m_cnt = 0;
    logic [7:0] m_a = '0, m_b = '0;
    logic [7:0] e_diff = '0;
    logic       e_bor = 1'b0, e_ovf = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt  <= 0;
            e_diff <= '0;
            e_bor  <= 1'b0;
            e_ovf  <= 1'b0;
        end else if (m_cnt == 0) begin
            if (start8) begin
                m_cnt <= 1;
                m_a   <= a8;
                m_b   <= b8;
            end
        end else if (m_cnt < 8) begin
            m_cnt <= m_cnt + 1;
        end else if (m_cnt == 8) begin
            logic [33:0] r;
            r = ref_sub(8, {24'd0, m_a}, {24'd0, m_b});
            m_cnt  <= 9;
            e_diff <= r[7:0];
            e_bor  <= r[32];
            e_ovf  <= r[33];
        end else begin
            m_cnt <= 0;
        end
    end

    // Per-cycle compare, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            logic [11:0] ev, av;
            ev = {(m_cnt >= 1 && m_cnt <= 8), (m_cnt == 9), e_diff, e_bor, e_ovf};
            av = {busy8, done8, diff8, bor8, ovf8};
            checks++;
            if (av !== ev) begin
                failures++;
                $display("FAIL cyc8 t=%0t {busy,done,diff,bor,ovf} got=%h want=%h",
                         $time, av, ev);
            end
        end
    end

    // Directed 8-bit op with literal expectations and latency check.
    task automatic run8(input logic [7:0] x, input logic [7:0] y,
                        input logic [7:0] ed, input logic eb, input logic eo,
                        input string nm);
        int lat;
        repeat (2) @(negedge clk);
        a8 = x; b8 = y; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (done8) begin lat = i; break; end
        end
        checks++;
        if (lat != 8 || diff8 !== ed || bor8 !== eb || ovf8 !== eo) begin
            failures++;
            $display("FAIL %s lat=%0d diff=%h bor=%b ovf=%b want lat=8 diff=%h bor=%b ovf=%b",
                     nm, lat, diff8, bor8, ovf8, ed, eb, eo);
        end
    endtask

    task automatic sweep4(input logic [3:0] x, input logic [3:0] y);
        int lat;
        logic [33:0] r;
        repeat (2) @(negedge clk);
        a4 = x; b4 = y; start4 = 1'b1;
        @(posedge clk); #1 start4 = 1'b0;
        lat = 0;
        for (int i = 1; i <= 12; i++) begin
            @(posedge clk); #1;
            if (done4) begin lat = i; break; end
        end
        r = ref_sub(4, {28'd0, x}, {28'd0, y});
        checks++;
        if (lat != 4 || diff4 !== r[3:0] || bor4 !== r[32] || ovf4 !== r[33]) begin
            failures++;
            $display("FAIL sweep4 a=%h b=%h lat=%0d diff=%h bor=%b ovf=%b want lat=4 diff=%h bor=%b ovf=%b",
                     x, y, lat, diff4, bor4, ovf4, r[3:0], r[32], r[33]);
        end
    endtask

    initial begin
        int lat, ndone;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        checks++;
        if ({busy8, done8, diff8, bor8, ovf8, busy4, done4, diff4, bor4, ovf4} !== '0) begin
            failures++;
            $display("FAIL reset_state got8=%b%b%h%b%b got4=%b%b%h%b%b want all zero",
                     busy8, done8, diff8, bor8, ovf8, busy4, done4, diff4, bor4, ovf4);
        end
        @(negedge clk) rst_n = 1'b1;

        run8(8'h05, 8'h03, 8'h02, 1'b0, 1'b0, "sub_5_3");
        run8(8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, "sub_3_5");
        run8(8'h80, 8'h01, 8'h7F, 1'b0, 1'b1, "sub_80_01");
        run8(8'h7F, 8'hFF, 8'h80, 1'b1, 1'b1, "sub_7F_FF");
        run8(8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0, "sub_equal");

        // start held high with new operands while busy: must be ignored.
        repeat (2) @(negedge clk);
        a8 = 8'h10; b8 = 8'h01; start8 = 1'b1;
        @(posedge clk); #1 a8 = 8'hFF; b8 = 8'h00;
        lat = 0; ndone = 0;
        for (int i = 1; i <= 16; i++) begin
            @(posedge clk); #1;
            if (done8) begin lat = i; ndone++; start8 = 1'b0; break; end
        end
        checks++;
        if (lat != 8 || ndone != 1 || diff8 !== 8'h0F || bor8 !== 1'b0 || ovf8 !== 1'b0) begin
            failures++;
            $display("FAIL hold_start lat=%0d diff=%h bor=%b ovf=%b want lat=8 diff=0f bor=0 ovf=0",
                     lat, diff8, bor8, ovf8);
        end

        // Reset during cycle 4 of an operation.
        repeat (3) @(negedge clk);
        a8 = 8'h33; b8 = 8'h11; start8 = 1'b1;
        @(posedge clk); #1 start8 = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({busy8, done8, diff8, bor8, ovf8} !== '0) begin
            failures++;
            $display("FAIL mid_reset got=%b%b%h%b%b want all zero",
                     busy8, done8, diff8, bor8, ovf8);
        end
        @(negedge clk) rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        checks++;
        if (ndone != 0) begin
            failures++;
            $display("FAIL abort_no_done got=%0d done pulses want 0", ndone);
        end

        // Random stimulus, start and operands toggling every cycle.
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            start8 = ($urandom_range(0, 3) == 0);
            a8 = 8'($urandom);
            b8 = 8'($urandom);
        end
        @(negedge clk) start8 = 1'b0;
        repeat (12) @(posedge clk);

        // Exhaustive WIDTH=4 sweep.
        for (int x = 0; x < 16; x++)
            for (int y = 0; y < 16; y++)
                sweep4(4'(x), 4'(y));

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
